// File: rtl/mii_pkg.sv
// rtl/mii_pkg.sv - control codes, word constants and FSM state type for the MII TX lane
package mii_pkg;

  localparam logic [7:0]  IDLE_CODE  = 8'h07;
  localparam logic [7:0]  START_CODE = 8'hFB;
  localparam logic [7:0]  EOF_CODE   = 8'hFD;

  localparam logic [63:0] IDLE_WORD  = {8{IDLE_CODE}};
  localparam logic [63:0] START_WORD = {{7{IDLE_CODE}}, START_CODE};
  localparam logic [63:0] EOF_WORD   = {{7{IDLE_CODE}}, EOF_CODE};
  localparam logic [7:0]  CTRL_WORD  = 8'hFF;
  localparam logic [7:0]  DATA_CTRL  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_EOF,
    ST_IFG
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter holding the last-served pointer
module rr_arb2 (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_adv,
  output logic [1:0] o_gnt
);

  // Starts at source 1 so source 0 wins the first tie.
  logic r_last;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = r_last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= 1'b1;
    end else if (i_adv && (|o_gnt)) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/mii_tx_scheduler.sv
// rtl/mii_tx_scheduler.sv - two-source round-robin frame scheduler driving the 64-bit MII TX lane
module mii_tx_scheduler
  import mii_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int IFG_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [1:0]            i_req,
  input  logic [LEN_WIDTH-1:0]  i_len0,
  input  logic [LEN_WIDTH-1:0]  i_len1,
  input  logic [DATA_WIDTH-1:0] i_data0,
  input  logic [DATA_WIDTH-1:0] i_data1,
  output logic [1:0]            o_grant,
  output logic [1:0]            o_rd,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic [CTRL_WIDTH-1:0] o_tx_ctrl
);

  localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [DATA_WIDTH-1:0] L_IDLE  = {(DATA_WIDTH/8){IDLE_CODE}};
  localparam logic [DATA_WIDTH-1:0] L_START = {{(DATA_WIDTH/8-1){IDLE_CODE}}, START_CODE};
  localparam logic [DATA_WIDTH-1:0] L_EOF   = {{(DATA_WIDTH/8-1){IDLE_CODE}}, EOF_CODE};
  localparam logic [CTRL_WIDTH-1:0] L_CTRL  = '1;
  localparam logic [CTRL_WIDTH-1:0] L_DATA  = '0;

  state_t                r_state;
  state_t                w_nstate;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [IFG_W-1:0]      r_ifg;
  logic [1:0]            r_grant;
  logic [1:0]            w_arb_gnt;
  logic                  w_any;
  logic                  w_adv;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [CTRL_WIDTH-1:0] r_tx_ctrl;

  assign w_any = |i_req;
  assign w_adv = (w_nstate == ST_START);

  rr_arb2 u_arb (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_req   (i_req),
    .i_adv   (w_adv),
    .o_gnt   (w_arb_gnt)
  );

  // r_cnt holds beats still to send; DATA is entered only while it is non-zero.
  always_comb begin
    w_nstate = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_nstate = ST_START;
      ST_START: w_nstate = (r_cnt != '0) ? ST_DATA : ST_EOF;
      ST_DATA:  w_nstate = (r_cnt != '0) ? ST_DATA : ST_EOF;
      ST_EOF: begin
        if (IFG_CYCLES > 0) w_nstate = ST_IFG;
        else                w_nstate = w_any ? ST_START : ST_IDLE;
      end
      ST_IFG:   if (r_ifg == '0) w_nstate = w_any ? ST_START : ST_IDLE;
      default:  w_nstate = ST_IDLE;
    endcase
  end

  assign o_rd      = (w_nstate == ST_DATA) ? r_grant : 2'b00;
  assign o_grant   = r_grant;
  assign o_tx_data = r_tx_data;
  assign o_tx_ctrl = r_tx_ctrl;

  // Output word is chosen by the state being entered, so the lane matches r_state.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ifg     <= '0;
      r_grant   <= 2'b00;
      r_tx_data <= L_IDLE;
      r_tx_ctrl <= L_CTRL;
    end else begin
      r_state <= w_nstate;
      case (w_nstate)
        ST_START: begin
          r_grant   <= w_arb_gnt;
          r_cnt     <= w_arb_gnt[1] ? i_len1 : i_len0;
          r_tx_data <= L_START;
          r_tx_ctrl <= L_CTRL;
        end
        ST_DATA: begin
          r_cnt     <= r_cnt - 1'b1;
          r_tx_data <= r_grant[1] ? i_data1 : i_data0;
          r_tx_ctrl <= L_DATA;
        end
        ST_EOF: begin
          r_tx_data <= L_EOF;
          r_tx_ctrl <= L_CTRL;
        end
        ST_IFG: begin
          r_grant   <= 2'b00;
          r_ifg     <= (r_state == ST_EOF) ? IFG_W'(IFG_CYCLES - 1) : r_ifg - 1'b1;
          r_tx_data <= L_IDLE;
          r_tx_ctrl <= L_CTRL;
        end
        default: begin
          r_grant   <= 2'b00;
          r_tx_data <= L_IDLE;
          r_tx_ctrl <= L_CTRL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mii_tx_scheduler.sv
// tb/tb_mii_tx_scheduler.sv - directed self-checking bench for mii_tx_scheduler
module tb_mii_tx_scheduler;

  localparam logic [63:0] W_IDLE  = 64'h0707070707070707;
  localparam logic [63:0] W_START = 64'h07070707070707FB;
  localparam logic [63:0] W_EOF   = 64'h07070707070707FD;

  typedef enum int {Y_I, Y_S0, Y_S1, Y_D0, Y_D1, Y_E0, Y_E1} sym_t;

  logic        clk;
  logic        i_rst_n;
  logic [1:0]  i_req;
  logic [7:0]  i_len0, i_len1;
  logic [63:0] i_data0, i_data1;
  logic [1:0]  o_grant, o_rd, o_grant_z, o_rd_z;
  logic [63:0] o_tx_data, o_tx_data_z;
  logic [7:0]  o_tx_ctrl, o_tx_ctrl_z;
  logic [47:0] idx0, idx1;
  int          n_vec = 0;
  int          n_err = 0;

  mii_tx_scheduler #(.IFG_CYCLES(2)) u_dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_len0(i_len0), .i_len1(i_len1),
    .i_data0(i_data0), .i_data1(i_data1), .o_grant(o_grant), .o_rd(o_rd),
    .o_tx_data(o_tx_data), .o_tx_ctrl(o_tx_ctrl)
  );

  mii_tx_scheduler #(.IFG_CYCLES(0)) u_dut0 (
    .clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_len0(i_len0), .i_len1(i_len1),
    .i_data0(i_data0), .i_data1(i_data1), .o_grant(o_grant_z), .o_rd(o_rd_z),
    .o_tx_data(o_tx_data_z), .o_tx_ctrl(o_tx_ctrl_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait-state sources: beat k of source n carries k in its low bits.
  assign i_data0 = {16'hD0D0, idx0};
  assign i_data1 = {16'hD1D1, idx1};
  always @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx0 <= '0;
      idx1 <= '0;
    end else begin
      if (o_rd[0]) idx0 <= idx0 + 1'b1;
      if (o_rd[1]) idx1 <= idx1 + 1'b1;
    end
  end

  function automatic logic [63:0] exp_word(sym_t s, logic [47:0] k);
    case (s)
      Y_S0, Y_S1: return W_START;
      Y_E0, Y_E1: return W_EOF;
      Y_D0:       return {16'hD0D0, k};
      Y_D1:       return {16'hD1D1, k};
      default:    return W_IDLE;
    endcase
  endfunction

  function automatic logic [7:0] exp_ctrl(sym_t s);
    return (s == Y_D0 || s == Y_D1) ? 8'h00 : 8'hFF;
  endfunction

  function automatic logic [1:0] exp_gnt(sym_t s);
    case (s)
      Y_S0, Y_D0, Y_E0: return 2'b01;
      Y_S1, Y_D1, Y_E1: return 2'b10;
      default:          return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_rd(sym_t next_s);
    return (next_s == Y_D0) ? 2'b01 : (next_s == Y_D1) ? 2'b10 : 2'b00;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    i_rst_n = 1'b0;
    i_req   = 2'b00;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({o_tx_data, o_tx_ctrl, o_grant, o_rd} !== {W_IDLE, 8'hFF, 2'b00, 2'b00}) begin
      n_err++;
      $display("FAIL reset_held: got %h/%h/%b/%b exp %h/ff/00/00", o_tx_data, o_tx_ctrl, o_grant, o_rd, W_IDLE);
    end
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({o_tx_data, o_tx_ctrl, o_grant, o_tx_data_z, o_tx_ctrl_z, o_grant_z} !==
          {W_IDLE, 8'hFF, 2'b00, W_IDLE, 8'hFF, 2'b00}) begin
        n_err++;
        $display("FAIL reset_idle cyc %0d: got %h/%h/%b z %h/%h/%b exp %h/ff/00", i,
                 o_tx_data, o_tx_ctrl, o_grant, o_tx_data_z, o_tx_ctrl_z, o_grant_z, W_IDLE);
      end
    end
  endtask

  task automatic test_single();
    sym_t t[$] = '{Y_S0, Y_D0, Y_D0, Y_D0, Y_E0, Y_I, Y_I, Y_I};
    logic [47:0] k0 = '0;
    logic [63:0] ed;
    @(negedge clk);
    i_req  = 2'b01;
    i_len0 = 8'd3;
    foreach (t[i]) begin
      @(negedge clk);
      ed = exp_word(t[i], k0);
      if (t[i] == Y_D0) k0++;
      n_vec++;
      if ({o_tx_data, o_tx_ctrl, o_grant} !== {ed, exp_ctrl(t[i]), exp_gnt(t[i])}) begin
        n_err++;
        $display("FAIL single cyc %0d: got %h/%h/%b exp %h/%h/%b", i, o_tx_data, o_tx_ctrl, o_grant,
                 ed, exp_ctrl(t[i]), exp_gnt(t[i]));
      end
      if (i + 1 < t.size()) begin
        n_vec++;
        if (o_rd !== exp_rd(t[i+1])) begin
          n_err++;
          $display("FAIL single_rd cyc %0d: got %b exp %b", i, o_rd, exp_rd(t[i+1]));
        end
      end
      if (i == 0) i_req = 2'b00;
    end
  endtask

  task automatic test_alternate();
    sym_t t[$] = '{Y_S0, Y_D0, Y_E0, Y_I, Y_I, Y_S1, Y_D1, Y_D1, Y_E1, Y_I, Y_I,
                   Y_S0, Y_D0, Y_E0, Y_I, Y_I, Y_S1, Y_D1, Y_D1, Y_E1};
    logic [47:0] k0 = '0;
    logic [47:0] k1 = '0;
    logic [63:0] ed;
    @(negedge clk);
    i_req  = 2'b11;
    i_len0 = 8'd1;
    i_len1 = 8'd2;
    foreach (t[i]) begin
      @(negedge clk);
      ed = exp_word(t[i], (t[i] == Y_D1) ? k1 : k0);
      if (t[i] == Y_D0) k0++;
      if (t[i] == Y_D1) k1++;
      n_vec++;
      if ({o_tx_data, o_tx_ctrl, o_grant} !== {ed, exp_ctrl(t[i]), exp_gnt(t[i])}) begin
        n_err++;
        $display("FAIL alternate cyc %0d: got %h/%h/%b exp %h/%h/%b", i, o_tx_data, o_tx_ctrl, o_grant,
                 ed, exp_ctrl(t[i]), exp_gnt(t[i]));
      end
      if (i + 1 < t.size()) begin
        n_vec++;
        if (o_rd !== exp_rd(t[i+1])) begin
          n_err++;
          $display("FAIL alternate_rd cyc %0d: got %b exp %b", i, o_rd, exp_rd(t[i+1]));
        end
      end
    end
    i_req = 2'b00;
  endtask

  task automatic test_zero_len();
    sym_t t[$] = '{Y_S1, Y_E1, Y_I, Y_I, Y_I};
    @(negedge clk);
    i_req  = 2'b10;
    i_len1 = 8'd0;
    foreach (t[i]) begin
      @(negedge clk);
      n_vec++;
      if ({o_tx_data, o_tx_ctrl, o_grant, o_rd} !==
          {exp_word(t[i], '0), exp_ctrl(t[i]), exp_gnt(t[i]), 2'b00}) begin
        n_err++;
        $display("FAIL zero_len cyc %0d: got %h/%h/%b/%b exp %h/%h/%b/00", i, o_tx_data, o_tx_ctrl,
                 o_grant, o_rd, exp_word(t[i], '0), exp_ctrl(t[i]), exp_gnt(t[i]));
      end
      if (i == 0) i_req = 2'b00;
    end
  endtask

  task automatic test_ifg0();
    sym_t t[$] = '{Y_S0, Y_D0, Y_E0, Y_S0, Y_D0, Y_E0, Y_S0};
    logic data_bad;
    @(negedge clk);
    i_req  = 2'b01;
    i_len0 = 8'd1;
    foreach (t[i]) begin
      @(negedge clk);
      data_bad = (t[i] != Y_D0) && (o_tx_data_z !== exp_word(t[i], '0));
      n_vec++;
      if (data_bad || ({o_tx_ctrl_z, o_grant_z} !== {exp_ctrl(t[i]), exp_gnt(t[i])})) begin
        n_err++;
        $display("FAIL ifg0 cyc %0d: got %h/%h/%b exp %h/%h/%b", i, o_tx_data_z, o_tx_ctrl_z, o_grant_z,
                 exp_word(t[i], '0), exp_ctrl(t[i]), exp_gnt(t[i]));
      end
      if (i + 1 < t.size()) begin
        n_vec++;
        if (o_rd_z !== exp_rd(t[i+1])) begin
          n_err++;
          $display("FAIL ifg0_rd cyc %0d: got %b exp %b", i, o_rd_z, exp_rd(t[i+1]));
        end
      end
    end
    i_req = 2'b00;
  endtask

  task automatic test_reset_mid();
    sym_t t[$] = '{Y_S0, Y_D0, Y_D0, Y_D0, Y_D0, Y_E0, Y_I, Y_I};
    logic [47:0] k0 = '0;
    logic [63:0] ed;
    @(negedge clk);
    i_req  = 2'b01;
    i_len0 = 8'd4;
    @(negedge clk);
    i_req = 2'b00;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_tx_data, o_tx_ctrl, o_grant, o_rd} !== {W_IDLE, 8'hFF, 2'b00, 2'b00}) begin
      n_err++;
      $display("FAIL mid_reset_async: got %h/%h/%b/%b exp %h/ff/00/00", o_tx_data, o_tx_ctrl, o_grant, o_rd, W_IDLE);
    end
    @(negedge clk);
    n_vec++;
    if ({o_tx_data, o_tx_ctrl, o_grant} !== {W_IDLE, 8'hFF, 2'b00}) begin
      n_err++;
      $display("FAIL mid_reset_hold: got %h/%h/%b exp %h/ff/00", o_tx_data, o_tx_ctrl, o_grant, W_IDLE);
    end
    i_rst_n = 1'b1;
    @(negedge clk);
    i_req = 2'b01;
    foreach (t[i]) begin
      @(negedge clk);
      ed = exp_word(t[i], k0);
      if (t[i] == Y_D0) k0++;
      n_vec++;
      if ({o_tx_data, o_tx_ctrl, o_grant} !== {ed, exp_ctrl(t[i]), exp_gnt(t[i])}) begin
        n_err++;
        $display("FAIL after_reset cyc %0d: got %h/%h/%b exp %h/%h/%b", i, o_tx_data, o_tx_ctrl, o_grant,
                 ed, exp_ctrl(t[i]), exp_gnt(t[i]));
      end
      if (i + 1 < t.size()) begin
        n_vec++;
        if (o_rd !== exp_rd(t[i+1])) begin
          n_err++;
          $display("FAIL after_reset_rd cyc %0d: got %b exp %b", i, o_rd, exp_rd(t[i+1]));
        end
      end
      if (i == 0) i_req = 2'b00;
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_req   = 2'b00;
    i_len0  = 8'd0;
    i_len1  = 8'd0;
    test_reset();
    do_reset();
    test_single();
    do_reset();
    test_alternate();
    do_reset();
    test_zero_len();
    do_reset();
    test_ifg0();
    do_reset();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
